// File: rtl/writeback_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dioptase_wb_pkg
//  Description : Shared encodings, FSM state type and lane constants for the
//                multi-slot writeback stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package dioptase_wb_pkg;

    // Load size encodings; the fourth code behaves as a full word.
    localparam logic [1:0] LD_BYTE = 2'd0;
    localparam logic [1:0] LD_HALF = 2'd1;
    localparam logic [1:0] LD_WORD = 2'd2;

    // Writeback FSM: idle, waiting on load data, draining a killed load.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } wb_state_e;

    // Lane geometry inside the low 32-bit memory word.
    localparam int c_byte_w        = 8;
    localparam int c_half_w        = 16;
    localparam int c_word_w        = 32;
    localparam int c_half_shift_lo = 0;
    localparam int c_half_shift_md = 8;
    localparam int c_half_shift_hi = 16;

endpackage : dioptase_wb_pkg
`default_nettype wire

// File: rtl/writeback_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_multi_if
//  Description : Slot-group, memory-response and register-file write bundle
//                of the writeback stage. master = memory stage / RF side,
//                slave = writeback stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface writeback_multi_if #(
    parameter int XLEN   = 32,
    parameter int NSLOTS = 2,
    parameter int RA_W   = 5
);
    logic                     halt;
    logic                     flush;
    logic                     valid_in;
    logic [NSLOTS-1:0]        slot_en;
    logic [NSLOTS*RA_W-1:0]   tgt_in;
    logic [NSLOTS-1:0]        no_wb;
    logic                     is_load;
    logic                     is_store;
    logic [1:0]               ld_size;
    logic                     ld_signed;
    logic [1:0]               addr_lo;
    logic [NSLOTS*XLEN-1:0]   alu_result;
    logic                     mem_rvalid;
    logic [XLEN-1:0]          mem_rdata;
    logic                     stall_out;
    logic [NSLOTS-1:0]        rf_we;
    logic [NSLOTS*RA_W-1:0]   rf_tgt;
    logic [NSLOTS*XLEN-1:0]   rf_data;

    modport master (
        output halt, flush, valid_in, slot_en, tgt_in, no_wb, is_load,
               is_store, ld_size, ld_signed, addr_lo, alu_result,
               mem_rvalid, mem_rdata,
        input  stall_out, rf_we, rf_tgt, rf_data
    );

    modport slave (
        input  halt, flush, valid_in, slot_en, tgt_in, no_wb, is_load,
               is_store, ld_size, ld_signed, addr_lo, alu_result,
               mem_rvalid, mem_rdata,
        output stall_out, rf_we, rf_tgt, rf_data
    );
endinterface : writeback_multi_if
`default_nettype wire

// File: rtl/writeback_multi_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational subword extraction of load data from the low
//                32 bits of the memory word, with zero/sign extension.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import dioptase_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      ld_size,
    input  logic            ld_signed,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] ld_data
);

    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_fill;

    assign w_word = mem_rdata[31:0];

    // Byte lane picked directly by the low address bits.
    always_comb begin
        w_byte = w_word[7:0];
        case (addr_lo)
            2'd0:    w_byte = w_word[0*c_byte_w +: c_byte_w];
            2'd1:    w_byte = w_word[1*c_byte_w +: c_byte_w];
            2'd2:    w_byte = w_word[2*c_byte_w +: c_byte_w];
            default: w_byte = w_word[3*c_byte_w +: c_byte_w];
        endcase
    end

    // Half lane: offset 1 straddles the middle bytes, offsets 2/3 share the top half.
    always_comb begin
        w_half = w_word[c_half_shift_lo +: c_half_w];
        case (addr_lo)
            2'd0:    w_half = w_word[c_half_shift_lo +: c_half_w];
            2'd1:    w_half = w_word[c_half_shift_md +: c_half_w];
            default: w_half = w_word[c_half_shift_hi +: c_half_w];
        endcase
    end

    // Fill the whole result with the extension bit, then overlay the lane.
    always_comb begin
        w_fill  = 1'b0;
        ld_data = '0;
        case (ld_size)
            LD_BYTE: begin
                w_fill                 = ld_signed & w_byte[c_byte_w-1];
                ld_data                = {XLEN{w_fill}};
                ld_data[c_byte_w-1:0]  = w_byte;
            end
            LD_HALF: begin
                w_fill                 = ld_signed & w_half[c_half_w-1];
                ld_data                = {XLEN{w_fill}};
                ld_data[c_half_w-1:0]  = w_half;
            end
            default: begin
                w_fill                 = ld_signed & w_word[c_word_w-1];
                ld_data                = {XLEN{w_fill}};
                ld_data[c_word_w-1:0]  = w_word;
            end
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/writeback_multi.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_multi
//  Description : Multi-slot writeback stage. Retires NSLOTS slots per cycle,
//                waits on variable-latency load data (stalling upstream),
//                drains flushed loads, arbitrates same-target writes (later
//                slot wins) and registers the register-file write ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_multi
    import dioptase_wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NSLOTS = 2,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    writeback_multi_if.slave  bus
);

    wb_state_e               r_state;
    wb_state_e               w_state_nxt;
    logic                    w_retire;
    logic                    w_stall;
    logic [NSLOTS-1:0]       w_elig;
    logic [NSLOTS-1:0]       w_we;
    logic [XLEN-1:0]         w_ld_data;
    logic [NSLOTS*XLEN-1:0]  w_data;
    logic [NSLOTS-1:0]       r_rf_we;
    logic [NSLOTS*RA_W-1:0]  r_rf_tgt;
    logic [NSLOTS*XLEN-1:0]  r_rf_data;

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .ld_size   (bus.ld_size),
        .ld_signed (bus.ld_signed),
        .addr_lo   (bus.addr_lo),
        .mem_rdata (bus.mem_rdata),
        .ld_data   (w_ld_data)
    );

    // Per-slot write eligibility and data source; only slot 0 can be a memory op.
    for (genvar gi = 0; gi < NSLOTS; gi++) begin : g_slot
        if (gi == 0) begin : g_mem_slot
            assign w_elig[gi] = bus.slot_en[gi] && (bus.tgt_in[gi*RA_W +: RA_W] != '0)
                                && !bus.no_wb[gi] && !bus.is_store;
            assign w_data[gi*XLEN +: XLEN] = bus.is_load ? w_ld_data
                                                         : bus.alu_result[gi*XLEN +: XLEN];
        end else begin : g_alu_slot
            assign w_elig[gi] = bus.slot_en[gi] && (bus.tgt_in[gi*RA_W +: RA_W] != '0)
                                && !bus.no_wb[gi];
            assign w_data[gi*XLEN +: XLEN] = bus.alu_result[gi*XLEN +: XLEN];
        end
    end

    // Same-target arbitration: an earlier slot yields to any later writer of its target.
    always_comb begin
        w_we = w_elig;
        for (int i = 0; i < NSLOTS; i++) begin
            for (int j = i + 1; j < NSLOTS; j++) begin
                if (w_elig[j] && (bus.tgt_in[j*RA_W +: RA_W] == bus.tgt_in[i*RA_W +: RA_W])) begin
                    w_we[i] = 1'b0;
                end
            end
        end
    end

    // Next state, retire decision and stall request from the current state.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            IDLE: begin
                w_retire = bus.valid_in && !bus.flush && (!bus.is_load || bus.mem_rvalid);
                if (bus.valid_in && !bus.flush && bus.is_load && !bus.mem_rvalid) begin
                    w_stall     = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                w_stall = !bus.mem_rvalid;
                if (bus.mem_rvalid) begin
                    // A flush arriving with the data kills the write but still closes the load.
                    w_retire    = bus.valid_in && !bus.flush;
                    w_state_nxt = IDLE;
                end else if (bus.flush) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_stall = 1'b1;
                if (bus.mem_rvalid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register; halt freezes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (!bus.halt) begin
            r_state <= w_state_nxt;
        end
    end

    // Register-file write port: captured on retire, enables pulse for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we   <= '0;
            r_rf_tgt  <= '0;
            r_rf_data <= '0;
        end else if (!bus.halt) begin
            if (w_retire) begin
                r_rf_we   <= w_we;
                r_rf_tgt  <= bus.tgt_in;
                r_rf_data <= w_data;
            end else begin
                r_rf_we   <= '0;
            end
        end
    end

    // Stall is forced low while reset is held so upstream never sees a stale request.
    assign bus.stall_out = rst_n && w_stall;
    assign bus.rf_we     = r_rf_we;
    assign bus.rf_tgt    = r_rf_tgt;
    assign bus.rf_data   = r_rf_data;

endmodule : writeback_multi
`default_nettype wire
